// File: rtl/st2bus_pack_pkg.sv
// Shared constants, FSM state type and bus-word assembly for the st2bus_pack byte-to-word packer.
package st2bus_pack_pkg;

    localparam int unsigned ST             = 8;
    localparam int unsigned BUS            = 534;
    localparam int unsigned PAYLOAD_W      = 512;
    localparam int unsigned BYTES_PER_WORD = PAYLOAD_W / ST;
    localparam int unsigned SEQ_W          = 14;
    localparam int unsigned CNT_W          = 6;
    localparam int unsigned CNT_LSB        = 512;
    localparam int unsigned SOP_BIT        = 518;
    localparam int unsigned EOP_BIT        = 519;
    localparam int unsigned SEQ_LSB        = 520;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    // nbytes is 1..64; the sideband count field carries nbytes-1
    function automatic logic [BUS-1:0] build_word(
        input logic [PAYLOAD_W-1:0] payload,
        input logic [6:0]           nbytes,
        input logic                 first,
        input logic                 last,
        input logic [SEQ_W-1:0]     seq
    );
        logic [CNT_W-1:0] cnt_field;
        cnt_field  = CNT_W'(nbytes - 7'd1);
        build_word = {seq, last, first, cnt_field, payload};
    endfunction

endpackage

// File: rtl/st2bus_obuf.sv
// Single-entry valid/ready output register; loads only when free (empty or draining this cycle).
module st2bus_obuf
    import st2bus_pack_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [BUS-1:0] load_data,
    input  logic           bus_ready,
    output logic [BUS-1:0] bus_data,
    output logic           bus_valid,
    output logic           free
);

    assign free = !bus_valid || bus_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
        end else if (load) begin
            bus_valid <= 1'b1;
            bus_data  <= load_data;
        end else if (bus_ready) begin
            bus_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/st2bus_pack.sv
// Packs an 8-bit Avalon-ST byte stream into 534-bit host-bus words (512 payload + 22 sideband).
// Define ST2BUS_SEQ_NUM_EN to carry the packet sequence number in bus_data[533:520].
module st2bus_pack
    import st2bus_pack_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     st_data,
    input  logic           st_valid,
    input  logic           st_sop,
    input  logic           st_eop,
    output logic           st_ready,
    output logic [BUS-1:0] bus_data,
    output logic           bus_valid,
    input  logic           bus_ready,
    output logic           pkt_err
);

    state_t                 state, state_n;
    logic [PAYLOAD_W-1:0]   acc, acc_n;
    logic [6:0]             cnt, cnt_n;
    logic                   first, first_n;
    logic                   last, last_n;
    logic                   pend_v, pend_v_n;
    logic [7:0]             pend_byte, pend_byte_n;
    logic                   pend_eop, pend_eop_n;
    logic                   err, err_n;

    logic                   st_xfer;
    logic                   obuf_free;
    logic                   load;
    logic [BUS-1:0]         load_word;
    logic [SEQ_W-1:0]       seq_cur;
    logic [PAYLOAD_W-1:0]   byte_word;
    logic [PAYLOAD_W-1:0]   acc_wr;
    logic [6:0]             cnt_inc;
    logic                   first_eff;

    assign st_ready  = !rst && (state != HOLD);
    assign st_xfer   = st_valid && st_ready;
    assign pkt_err   = err;
    assign byte_word = {{(PAYLOAD_W-8){1'b0}}, st_data};
    assign acc_wr    = acc | (byte_word << {cnt[5:0], 3'b000});
    assign cnt_inc   = cnt + 7'd1;

`ifdef ST2BUS_SEQ_NUM_EN
    logic [SEQ_W-1:0] seq;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
        end else if (load && load_word[EOP_BIT]) begin
            seq <= seq + 1'b1;
        end
    end

    assign seq_cur = seq;
`else
    assign seq_cur = '0;
`endif

    st2bus_obuf u_obuf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_word),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .free      (obuf_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            first     <= 1'b0;
            last      <= 1'b0;
            pend_v    <= 1'b0;
            pend_byte <= '0;
            pend_eop  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            first     <= first_n;
            last      <= last_n;
            pend_v    <= pend_v_n;
            pend_byte <= pend_byte_n;
            pend_eop  <= pend_eop_n;
            err       <= err_n;
        end
    end

    // HOLD always means acc holds a closed word (cnt bytes, first/last flags) waiting for obuf;
    // pend_* keeps a sop byte that interrupted a packet while obuf was busy.
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        first_n     = first;
        last_n      = last;
        pend_v_n    = pend_v;
        pend_byte_n = pend_byte;
        pend_eop_n  = pend_eop;
        err_n       = err;
        load        = 1'b0;
        load_word   = '0;
        first_eff   = first;

        case (state)
            IDLE, FILL: begin
                if (st_xfer) begin
                    if (state == FILL && st_sop && cnt != 7'd0) begin
                        err_n = 1'b1;
                        if (obuf_free) begin
                            load      = 1'b1;
                            load_word = build_word(acc, cnt, first, 1'b1, seq_cur);
                            acc_n     = byte_word;
                            cnt_n     = 7'd1;
                            first_n   = 1'b1;
                            last_n    = st_eop;
                            state_n   = st_eop ? HOLD : FILL;
                        end else begin
                            last_n      = 1'b1;
                            pend_v_n    = 1'b1;
                            pend_byte_n = st_data;
                            pend_eop_n  = st_eop;
                            state_n     = HOLD;
                        end
                    end else if (state == IDLE && !st_sop) begin
                        if (st_eop) begin
                            err_n = 1'b1;
                        end
                    end else begin
                        if (st_sop) begin
                            first_eff = 1'b1;
                        end
                        if (state == FILL && st_sop) begin
                            err_n = 1'b1;
                        end
                        if (st_eop || cnt == 7'(BYTES_PER_WORD - 1)) begin
                            if (obuf_free) begin
                                load      = 1'b1;
                                load_word = build_word(acc_wr, cnt_inc, first_eff, st_eop, seq_cur);
                                acc_n     = '0;
                                cnt_n     = '0;
                                first_n   = 1'b0;
                                last_n    = 1'b0;
                                state_n   = st_eop ? IDLE : FILL;
                            end else begin
                                acc_n   = acc_wr;
                                cnt_n   = cnt_inc;
                                first_n = first_eff;
                                last_n  = st_eop;
                                state_n = HOLD;
                            end
                        end else begin
                            acc_n   = acc_wr;
                            cnt_n   = cnt_inc;
                            first_n = first_eff;
                            state_n = FILL;
                        end
                    end
                end
            end

            HOLD: begin
                if (obuf_free) begin
                    load      = 1'b1;
                    load_word = build_word(acc, cnt, first, last, seq_cur);
                    if (pend_v) begin
                        acc_n    = {{(PAYLOAD_W-8){1'b0}}, pend_byte};
                        cnt_n    = 7'd1;
                        first_n  = 1'b1;
                        last_n   = pend_eop;
                        pend_v_n = 1'b0;
                        state_n  = pend_eop ? HOLD : FILL;
                    end else begin
                        acc_n   = '0;
                        cnt_n   = '0;
                        first_n = 1'b0;
                        last_n  = 1'b0;
                        state_n = last ? IDLE : FILL;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_st2bus_pack.sv
// Self-checking bench for st2bus_pack: vector table, directed corner cases and randomized traffic vs. a packet-level model.
module tb_st2bus_pack;
    import st2bus_pack_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     st_data;
    logic           st_valid;
    logic           st_sop;
    logic           st_eop;
    logic           st_ready;
    logic [BUS-1:0] bus_data;
    logic           bus_valid;
    logic           bus_ready;
    logic           pkt_err;

    st2bus_pack dut (
        .clk       (clk),
        .rst       (rst),
        .st_data   (st_data),
        .st_valid  (st_valid),
        .st_sop    (st_sop),
        .st_eop    (st_eop),
        .st_ready  (st_ready),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int br_mode = 0;
    int unsigned n_acc = 0;
    int unsigned n_stall = 0;
    bit done;

    logic [BUS-1:0] got_q[$];
    logic [BUS-1:0] exp_q[$];

    // packet-level reference: bytes of the current word, packet/first flags, sticky error, sequence
    logic [7:0]  m_cur[$];
    bit          m_in_pkt;
    bit          m_first;
    bit          m_err;
    int unsigned m_seq;

    task automatic check_w(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void m_emit(input bit is_last);
        logic [BUS-1:0] w;
        w = '0;
        foreach (m_cur[k]) w[8*k +: 8] = m_cur[k];
        w[CNT_LSB +: 6] = 6'(m_cur.size() - 1);
        w[SOP_BIT] = m_first;
        w[EOP_BIT] = is_last;
`ifdef ST2BUS_SEQ_NUM_EN
        w[SEQ_LSB +: SEQ_W] = SEQ_W'(m_seq);
`endif
        exp_q.push_back(w);
        m_cur.delete();
        m_first = 1'b0;
        if (is_last) m_seq = (m_seq + 1) % (1 << SEQ_W);
    endfunction

    function automatic void m_start(input logic [7:0] d, input bit e);
        m_cur.delete();
        m_cur.push_back(d);
        m_first  = 1'b1;
        m_in_pkt = 1'b1;
        if (e) begin
            m_emit(1'b1);
            m_in_pkt = 1'b0;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] d, input bit s, input bit e);
        if (!m_in_pkt) begin
            if (s) m_start(d, e);
            else if (e) m_err = 1'b1;
        end else if (s) begin
            m_err = 1'b1;
            if (m_cur.size() > 0) m_emit(1'b1);
            m_start(d, e);
        end else begin
            m_cur.push_back(d);
            if (e) begin
                m_emit(1'b1);
                m_in_pkt = 1'b0;
            end else if (m_cur.size() == BYTES_PER_WORD) begin
                m_emit(1'b0);
            end
        end
    endfunction

    function automatic void model_reset();
        m_cur.delete();
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_first  = 1'b0;
        m_err    = 1'b0;
        m_seq    = 0;
    endfunction

    task automatic send(input logic [7:0] d, input bit s, input bit e);
        logic rdy;
        bit   ok;
        ok       = 1'b0;
        st_data  = d;
        st_sop   = s;
        st_eop   = e;
        st_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rdy = st_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            n_stall++;
        end
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        if (ok) begin
            n_acc++;
            model_byte(d, s, e);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got st_ready=0 for 3000 cycles expected acceptance");
        end
    endtask

    task automatic send_pkt(input int len, input bit with_eop);
        for (int i = 0; i < len; i++) begin
            send(8'($urandom), (i == 0), (with_eop && i == len - 1));
        end
    endtask

    task automatic drain();
        br_mode = 0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic compare_words(input string tag);
        drain();
        check_i({tag, " words"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_w($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
        end
        check_i({tag, " pkt_err"}, int'(pkt_err), int'(m_err));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_i("rst st_ready", int'(st_ready), 0);
        check_i("rst bus_valid", int'(bus_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (br_mode)
                0:       bus_ready = 1'b1;
                1:       bus_ready = 1'($urandom_range(0, 1));
                default: bus_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_valid && bus_ready) got_q.push_back(bus_data);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int len;
        int words;
        int last_cnt;
    } vec_t;

    vec_t           tbl[8];
    logic [BUS-1:0] lw;
    logic [BUS-1:0] snap;
    int             len;
    int             gap;
    bit             noeop;
    int             li;

    initial begin
        tbl[0] = '{1, 1, 0};
        tbl[1] = '{2, 1, 1};
        tbl[2] = '{63, 1, 62};
        tbl[3] = '{64, 1, 63};
        tbl[4] = '{65, 2, 0};
        tbl[5] = '{130, 3, 1};
        tbl[6] = '{128, 2, 63};
        tbl[7] = '{200, 4, 7};

        rst      = 1'b1;
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        st_data  = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check_i("reset st_ready", int'(st_ready), 0);
        check_i("reset bus_valid", int'(bus_valid), 0);
        check_w("reset bus_data", bus_data, '0);
        check_i("reset pkt_err", int'(pkt_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_i("post-reset st_ready", int'(st_ready), 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            send_pkt(tbl[v].len, 1'b1);
            drain();
            check_i($sformatf("tbl%0d words", v), got_q.size(), tbl[v].words);
            if (got_q.size() == tbl[v].words) begin
                li = tbl[v].words - 1;
                lw = got_q[li];
                check_i($sformatf("tbl%0d last cnt", v), int'(lw[CNT_LSB +: 6]), tbl[v].last_cnt);
                check_i($sformatf("tbl%0d last eop", v), int'(lw[EOP_BIT]), 1);
                check_i($sformatf("tbl%0d first sop", v), int'(got_q[0][SOP_BIT]), 1);
                check_w($sformatf("tbl%0d zero fill", v), BUS'(lw[PAYLOAD_W-1:0] >> (8 * (tbl[v].last_cnt + 1))), '0);
            end
            compare_words($sformatf("tbl%0d", v));
        end

        n_stall = 0;
        send_pkt(1024, 1'b1);
        check_i("1024 stalls", n_stall, 0);
        drain();
        check_i("1024 words", got_q.size(), 16);
        if (got_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                lw = got_q[i];
                check_i($sformatf("1024 cnt%0d", i), int'(lw[CNT_LSB +: 6]), 63);
                check_i($sformatf("1024 sop%0d", i), int'(lw[SOP_BIT]), (i == 0) ? 1 : 0);
                check_i($sformatf("1024 eop%0d", i), int'(lw[EOP_BIT]), (i == 15) ? 1 : 0);
            end
        end
        compare_words("1024");

        br_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        n_acc = 0;
        done  = 1'b0;
        fork
            begin
                send_pkt(300, 1'b1);
                done = 1'b1;
            end
        join_none
        repeat (100) @(negedge clk);
        snap = bus_data;
        repeat (50) @(negedge clk);
        check_i("hold accepted", n_acc, 128);
        check_i("hold st_ready", int'(st_ready), 0);
        check_i("hold bus_valid", int'(bus_valid), 1);
        check_w("hold stable", bus_data, snap);
        if (exp_q.size() > 0) check_w("hold obuf word0", bus_data, exp_q[0]);
        br_mode = 0;
        for (int i = 0; i < 3000 && !done; i++) @(posedge clk);
        #1;
        check_i("hold resume done", int'(done), 1);
        compare_words("hold");

        check_i("pkt_err before errors", int'(pkt_err), 0);
        send_pkt(50, 1'b0);
        send_pkt(10, 1'b1);
        drain();
        check_i("sop err words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            lw = got_q[0];
            check_i("sop err cnt", int'(lw[CNT_LSB +: 6]), 49);
            check_i("sop err eop", int'(lw[EOP_BIT]), 1);
            lw = got_q[1];
            check_i("sop err new sop", int'(lw[SOP_BIT]), 1);
            check_i("sop err new cnt", int'(lw[CNT_LSB +: 6]), 9);
        end
        check_i("sop err pkt_err", int'(pkt_err), 1);
        compare_words("sop err");

        do_reset();
        check_i("pkt_err cleared", int'(pkt_err), 0);
        send(8'hAA, 1'b0, 1'b1);
        drain();
        check_i("stray eop words", got_q.size(), 0);
        check_i("stray eop pkt_err", int'(pkt_err), 1);
        compare_words("stray eop");

        do_reset();
        send(8'h5C, 1'b1, 1'b1);
        drain();
        check_i("single words", got_q.size(), 1);
        if (got_q.size() == 1) begin
            lw = got_q[0];
            check_i("single cnt", int'(lw[CNT_LSB +: 6]), 0);
            check_i("single flags", int'(lw[EOP_BIT:SOP_BIT]), 3);
            check_i("single byte", int'(lw[7:0]), 8'h5C);
        end
        compare_words("single");

        send_pkt(20, 1'b0);
        compare_words("pre-reset");
        do_reset();
        send_pkt(64, 1'b1);
        send_pkt(5, 1'b1);
        drain();
        check_i("rst words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            lw = got_q[0];
            check_i("rst seq0", int'(lw[SEQ_LSB +: SEQ_W]), 0);
            lw = got_q[1];
`ifdef ST2BUS_SEQ_NUM_EN
            check_i("rst seq1", int'(lw[SEQ_LSB +: SEQ_W]), 1);
`else
            check_i("rst seq1", int'(lw[SEQ_LSB +: SEQ_W]), 0);
`endif
        end
        compare_words("rst mid");

        br_mode = 1;
        for (int p = 0; p < 200; p++) begin
            len   = $urandom_range(1, 150);
            noeop = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            send_pkt(len, !noeop);
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
        end
        compare_words("random");

        do_reset();
        for (int p = 0; p < (1 << SEQ_W) + 1; p++) begin
            send(8'($urandom), 1'b1, 1'b1);
        end
        compare_words("seq wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
